// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
// Holds the mult/div state encoding, the zero register id and the stall counter width.
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 16;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks an in-flight mult/div operation: start launches it, busy is high for MD_CYCLES cycles.
// Ports: clk, rst_n (async, active-low), start (one-cycle launch pulse), busy (registered).
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

    md_state_t     state;
    logic [CW-1:0] cnt;

    // A start while busy cannot occur: the hazard logic holds any
    // mult/div in ID until busy drops, so it is ignored here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt == '0) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller beside ID: load-use stalls, taken-branch flushes, mult/div sequencing.
// Ports: ID/EX hazard inputs in; pc/ifid enables, flush, bubble, md_start, md_busy, stall_cnt out.
module hazard_scheduler
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_md_op,
    input  logic                   id_hilo_rd,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic load_use;
    logic md_hazard;
    logic flush;
    logic sel_flush;
    logic sel_stall;
    logic sel_norm;

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs && (ex_rd == id_rs)) ||
                       (id_uses_rt && (ex_rd == id_rt)));

    assign md_hazard = md_busy && (id_hilo_rd || id_md_op);
    assign flush     = ex_branch_taken;

    // One-hot selects encode flush > stall > normal.
    assign sel_flush = flush;
    assign sel_stall = !flush && (load_use || md_hazard);
    assign sel_norm  = !flush && !load_use && !md_hazard;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        unique case (1'b1)
            sel_flush: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            sel_stall: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            sel_norm: begin
                pc_write    = 1'b1;
            end
            default: begin
                pc_write    = 1'b1;
            end
        endcase
    end

    // Launch only when the mult/div actually leaves ID.
    assign md_start = id_md_op && sel_norm;

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .busy  (md_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage, next to the EX/MEM forwarding logic. It stalls PC and IF/ID and injects ID/EX bubbles on load-use hazards. It flushes IF/ID on taken branches resolved in EX. It also sequences the multi-cycle mult/div unit: it issues its start pulse and holds dependent HI/LO readers and back-to-back mult/div until the unit finishes.

## Interface
- MD_CYCLES, default 32: mult/div latency in cycles, legal range ≥2.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_md_op  in  1  ID instruction is mult/multu/div/divu.
- id_hilo_rd  in  1  ID instruction is mfhi/mflo.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to a nop.
- idex_bubble  out  1  load a nop into ID/EX.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  mult/div unit in progress, registered.
- stall_cnt  out  16  saturating count of cycles with pc_write=0.

## Operation
Hazard terms, all combinational:
- **load_use** = ex_mem_read && ex_rd≠0 && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)).
- **md_hazard** = md_busy && (id_hilo_rd || id_md_op).
- **flush** = ex_branch_taken.

Priority is flush > load_use > md_hazard > normal.
- **flush:** ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. The ID instruction is squashed, so no stall and no md_start.
- **load_use or md_hazard (stall):** pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- **normal:** pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.

md_start = id_md_op && !flush && !load_use && !md_hazard. It fires only in the cycle the mult/div instruction leaves ID.

Mult/div state machine (MD_IDLE, MD_BUSY):
- MD_IDLE → MD_BUSY on md_start; cnt loads MD_CYCLES-1.
- In MD_BUSY, cnt decrements each cycle.
- MD_BUSY → MD_IDLE when cnt==0 at a clock edge.
- md_busy = (state==MD_BUSY).
- A later flush does not cancel an issued operation, because mult/div is older than any branch that resolves after it.

Other rules:
- Independent instructions, i.e. neither id_hilo_rd nor id_md_op, proceed while md_busy.
- stall_cnt increments every cycle pc_write=0 and saturates at 16'hFFFF.
- Counter width is $clog2(MD_CYCLES).
- Reset values: state=MD_IDLE, cnt=0, md_busy=0, stall_cnt=0. Combinational outputs then take their normal values.
- Reset asserted mid-operation drops md_busy immediately, asynchronously.

## Timing
- All stall, flush and bubble outputs and md_start are combinational, in the same cycle as their inputs. md_busy and stall_cnt are registered.
- md_start in cycle T → md_busy high in cycles T+1 … T+MD_CYCLES, low from T+MD_CYCLES+1.
- mfhi in ID during cycles T+1 … T+MD_CYCLES stalls. It advances in cycle T+MD_CYCLES+1.
- A second mult/div held the same way issues md_start in T+MD_CYCLES+1, with no gap cycle.
- Load-use stalls exactly one cycle. Next cycle the load is in MEM, ex_mem_read deasserts, and forwarding supplies the value.
- Flush plus load_use in the same cycle: flush only, no stall, stall_cnt unchanged.

## Structure
- Shared package pipe_pkg holds:
  - md_state_t enum {MD_IDLE, MD_BUSY};
  - REG_ZERO = 5'd0;
  - STALL_CNT_W = 16.
- Sub-module md_busy_timer (params MD_CYCLES; ports clk, rst_n, start, busy) holds the state machine and down-counter.
- The top level holds the hazard decode, the priority mux and stall_cnt.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1, and stall_cnt 0→1. With ex_rd=0 instead → no stall.
- **Branch flush over load-use:** ex_branch_taken=1 together with the load-use inputs above → ifid_flush=1, idex_bubble=1, pc_write=1, stall_cnt unchanged.
- **mult then mfhi (MD_CYCLES=4):** md_start at cycle 0; md_busy cycles 1–4; mfhi in ID stalls cycles 1–4 and advances cycle 5; stall_cnt=4.
- **Back-to-back div:** second div in ID during busy → held; md_start at cycle 5; md_busy cycles 6–9. An independent add in ID while busy → no stall.
- **Flush vs. md_start:** id_md_op=1 with ex_branch_taken=1 → md_start=0 and md_busy stays 0. Flush while md_busy → busy continues to term.
- **Reset mid-busy:** rst_n low at cycle 2 of busy → md_busy=0 and stall_cnt=0 immediately. After release, mfhi proceeds without stall.
